// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared pipeline widths, reset PC and fetch FSM encoding
package fetch_sequencer_pkg;
    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 19;
    localparam int CNT_W   = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - priority mux choosing next pc and the IF/ID advance/squash controls
module pc_next_sel
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = 12
) (
    input  fetch_state_t  state,
    input  logic [AW-1:0] pc,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    input  logic          jmp,
    input  logic [AW-1:0] jmp_target,
    input  logic          halt,
    output logic [AW-1:0] next_pc,
    output logic [AW-1:0] pc_plus1,
    output logic          advance,
    output logic          squash,
    output logic          enter_halt
);
    assign pc_plus1 = pc + AW'(1);

    always_comb begin
        next_pc    = pc;
        advance    = 1'b0;
        squash     = 1'b0;
        enter_halt = 1'b0;
        // Only RUN moves the PC; BOOT and HALTED hold it.
        if (state == ST_RUN) begin
            if (br_taken) begin
                next_pc = br_target;
                squash  = 1'b1;
            end else if (halt) begin
                squash     = 1'b1;
                enter_halt = 1'b1;
            end else if (jmp) begin
                next_pc = jmp_target;
                squash  = 1'b1;
            end else if (!stall) begin
                next_pc = pc_plus1;
                advance = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - owns the PC, drives imem address and loads the IF/ID register
module fetch_sequencer #(
    parameter int ADDR_W  = fetch_sequencer_pkg::ADDR_W,
    parameter int INSTR_W = fetch_sequencer_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_sequencer_pkg::RESET_PC,
    parameter int CNT_W   = fetch_sequencer_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               jmp,
    input  logic [ADDR_W-1:0]  jmp_target,
    input  logic               halt,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc1,
    output logic               ifid_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_cnt
);
    import fetch_sequencer_pkg::*;

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, next_pc, pc_plus1;
    logic              advance, squash, enter_halt;

    assign imem_addr = pc;

    pc_next_sel #(.AW(ADDR_W)) u_pc_next_sel (
        .state      (state),
        .pc         (pc),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .halt       (halt),
        .next_pc    (next_pc),
        .pc_plus1   (pc_plus1),
        .advance    (advance),
        .squash     (squash),
        .enter_halt (enter_halt)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  if (enter_halt) state_next = ST_HALTED;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BOOT;
            pc         <= RESET_PC;
            ifid_instr <= '0;
            ifid_pc1   <= '0;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            state  <= state_next;
            pc     <= next_pc;
            halted <= (state_next == ST_HALTED);
            // The word at pc is captured on the same edge that advances pc.
            if (advance) begin
                ifid_instr <= imem_data;
                ifid_pc1   <= pc_plus1;
                ifid_valid <= 1'b1;
                fetch_cnt  <= fetch_cnt + CNT_W'(1);
            end else if (squash || state != ST_RUN) begin
                ifid_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench against a behavioural fetch model
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] imem_addr;
    logic [18:0] imem_data;
    logic        stall, br_taken, jmp, halt;
    logic [11:0] br_target, jmp_target;
    logic [18:0] ifid_instr;
    logic [11:0] ifid_pc1;
    logic        ifid_valid, halted;
    logic [15:0] fetch_cnt;

    logic [18:0] mem [4096];
    int checks = 0;
    int failures = 0;

    // Behavioural model: 0=boot, 1=run, 2=halted
    int          m_mode;
    int          m_pc;
    logic [18:0] m_instr;
    int          m_pc1;
    bit          m_valid;
    int          m_cnt;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .halt       (halt),
        .ifid_instr (ifid_instr),
        .ifid_pc1   (ifid_pc1),
        .ifid_valid (ifid_valid),
        .halted     (halted),
        .fetch_cnt  (fetch_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit b, input int bt,
                              input bit j, input int jt, input bit h);
        if (r) begin
            m_mode = 0; m_pc = 0; m_instr = '0; m_pc1 = 0; m_valid = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_valid = 0;
        end else if (m_mode == 1) begin
            if (b) begin
                m_pc = bt; m_valid = 0;
            end else if (h) begin
                m_mode = 2; m_valid = 0;
            end else if (j) begin
                m_pc = jt; m_valid = 0;
            end else if (!s) begin
                m_instr = mem[m_pc];
                m_pc    = (m_pc + 1) % 4096;
                m_pc1   = m_pc;
                m_valid = 1;
                m_cnt   = (m_cnt + 1) % 65536;
            end
        end
    endtask

    task automatic cycle(input string tag, input bit r, input bit s, input bit b, input int bt,
                         input bit j, input int jt, input bit h);
        rst = r; stall = s; br_taken = b; br_target = 12'(bt);
        jmp = j; jmp_target = 12'(jt); halt = h;
        model_edge(r, s, b, bt, j, jt, h);
        @(posedge clk);
        #1;
        check({tag, ".addr"},  32'(imem_addr),  32'(m_pc));
        check({tag, ".instr"}, 32'(ifid_instr), 32'(m_instr));
        check({tag, ".pc1"},   32'(ifid_pc1),   32'(m_pc1));
        check({tag, ".valid"}, 32'(ifid_valid), 32'(m_valid));
        check({tag, ".halted"},32'(halted),     32'(m_mode == 2));
        check({tag, ".cnt"},   32'(fetch_cnt),  32'(m_cnt));
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 19'($urandom);
        rst = 1; stall = 0; br_taken = 0; br_target = '0; jmp = 0; jmp_target = '0; halt = 0;
        @(negedge clk);

        // 1: reset, boot bubble, then words 0..2
        cycle("t1_rst", 1, 0, 0, 0, 0, 0, 0);
        check("t1_rst_valid", 32'(ifid_valid), 32'd0);
        idle("t1_boot");
        check("t1_boot_valid", 32'(ifid_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            idle("t1_run");
            check("t1_pc1", 32'(ifid_pc1), 32'(k + 1));
            check("t1_word", 32'(ifid_instr), 32'(mem[k]));
        end
        check("t1_cnt", 32'(fetch_cnt), 32'd3);

        // 2: stall three cycles at pc=5
        idle("t2_a"); idle("t2_b");
        check("t2_pc5", 32'(imem_addr), 32'd5);
        for (int k = 0; k < 3; k++) cycle("t2_stall", 0, 1, 0, 0, 0, 0, 0);
        check("t2_hold_addr", 32'(imem_addr), 32'd5);
        check("t2_hold_cnt", 32'(fetch_cnt), 32'd5);
        idle("t2_release");
        check("t2_word5", 32'(ifid_instr), 32'(mem[5]));

        // 3: branch wins over stall and jmp
        cycle("t3_br", 0, 1, 1, 12'h100, 1, 12'h222, 0);
        check("t3_addr", 32'(imem_addr), 32'h100);
        check("t3_bubble", 32'(ifid_valid), 32'd0);
        idle("t3_next");
        check("t3_pc1", 32'(ifid_pc1), 32'h101);

        // 4: wrap at 4095
        cycle("t4_jmp", 0, 0, 0, 0, 1, 4095, 0);
        idle("t4_wrap");
        check("t4_pc1", 32'(ifid_pc1), 32'd0);
        check("t4_addr", 32'(imem_addr), 32'd0);

        // 5: halt beats jmp, then everything is ignored until rst
        cycle("t5_halt", 0, 0, 0, 0, 1, 12'h333, 1);
        check("t5_halted", 32'(halted), 32'd1);
        cycle("t5_ign_br", 0, 0, 1, 12'h444, 0, 0, 0);
        cycle("t5_ign_jmp", 0, 1, 0, 0, 1, 12'h555, 0);
        check("t5_frozen", 32'(imem_addr), 32'd0);
        cycle("t5_rst", 1, 0, 0, 0, 0, 0, 0);
        check("t5_unhalt", 32'(halted), 32'd0);

        // 6: rst wins over jmp
        idle("t6_boot"); idle("t6_run");
        cycle("t6_rst_jmp", 1, 0, 0, 0, 1, 12'h777, 0);
        check("t6_addr", 32'(imem_addr), 32'd0);
        check("t6_cnt", 32'(fetch_cnt), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle("rnd",
                  $urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 4095)),
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 4095)),
                  $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
